// File: rtl/fidget_debug_pkg.sv
// Shared definitions for the fidget debug blocks (bus_recorder, debug_controller).
// Holds the recorder state encoding, sample layout and command codes.
package fidget_debug_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDump,
    StDone
  } rec_state_e;

  localparam int unsigned SampleWidth    = 24;
  localparam int unsigned BytesPerSample = 3;
  localparam logic [7:0]  CMD_RECORD     = 8'h30;

  typedef logic [SampleWidth-1:0] sample_t;

  // Byte idx of a sample, most significant byte first.
  function automatic logic [7:0] sample_byte(sample_t s, logic [1:0] idx);
    case (idx)
      2'd0:    return s[23:16];
      2'd1:    return s[15:8];
      default: return s[7:0];
    endcase
  endfunction

endpackage

// File: rtl/bus_recorder_if.sv
// Sampled target bus plus the byte stream towards the serial transmit FIFO.
// slave is the recorder side, master is whoever drives the bus and the FIFO ready.
interface bus_recorder_if;
  logic [15:0] bus_address;
  logic [7:0]  bus_data;
  logic        bus_strobe;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output bus_address, bus_data, bus_strobe, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  bus_address, bus_data, bus_strobe, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/sample_ram.sv
// Simple dual-port RAM, one write port and one synchronous read port.
// Contents are deliberately not reset.
module sample_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 24,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/bus_recorder.sv
// Captures DEPTH strobed {address, data} samples after record_start, then streams
// them out as three bytes per sample and pulses record_done.
module bus_recorder
  import fidget_debug_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic          comm_clock,
  input  logic          comm_reset,
  input  logic          record_start,
  output logic          record_done,
  output logic          busy,
  bus_recorder_if.slave bus
);

  localparam int unsigned     AddrW    = $clog2(DEPTH);
  localparam logic [AddrW-1:0] LastIdx = AddrW'(DEPTH - 1);
  localparam logic [AddrW:0]   RdEnd   = (AddrW + 1)'(DEPTH);
  localparam logic [1:0]       LastByte = 2'(BytesPerSample - 1);

  rec_state_e       state_q, state_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, sent_q, sent_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             rd_pend_q, rd_pend_d;
  sample_t          cur_q, cur_d, nxt_q, nxt_d;
  logic             cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
  logic [1:0]       byte_sel_q, byte_sel_d;
  logic             ram_we;
  sample_t          ram_rdata;
  logic             fire, consume, cur_left, issue;
  logic [1:0]       occ;

  assign fire     = cur_vld_q & bus.out_ready;
  assign consume  = fire & (byte_sel_q == LastByte);
  assign cur_left = cur_vld_q & ~consume;
  // cur + nxt + in-flight read form a two-entry prefetch queue in front of the output.
  assign occ      = {1'b0, cur_left} + {1'b0, nxt_vld_q} + {1'b0, rd_pend_q};
  assign issue    = (state_q == StDump) && (occ < 2'd2) && (rd_ptr_q != RdEnd);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    sent_d     = sent_q;
    rd_ptr_d   = rd_ptr_q;
    rd_pend_d  = 1'b0;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    cur_vld_d  = cur_vld_q;
    nxt_vld_d  = nxt_vld_q;
    byte_sel_d = byte_sel_q;
    ram_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (record_start) begin
          state_d    = StCapture;
          wr_ptr_d   = '0;
          sent_d     = '0;
          rd_ptr_d   = '0;
          cur_vld_d  = 1'b0;
          nxt_vld_d  = 1'b0;
          byte_sel_d = '0;
        end
      end
      StCapture: begin
        if (bus.bus_strobe) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LastIdx) state_d = StDump;
        end
      end
      StDump: begin
        rd_pend_d = issue;
        rd_ptr_d  = rd_ptr_q + {{AddrW{1'b0}}, issue};
        if (fire) byte_sel_d = consume ? 2'd0 : byte_sel_q + 2'd1;
        cur_vld_d = cur_left;
        if (!cur_left && nxt_vld_q) begin
          cur_d     = nxt_q;
          cur_vld_d = 1'b1;
          nxt_vld_d = 1'b0;
        end
        if (rd_pend_q) begin
          if (!cur_vld_d) begin
            cur_d     = ram_rdata;
            cur_vld_d = 1'b1;
          end else begin
            nxt_d     = ram_rdata;
            nxt_vld_d = 1'b1;
          end
        end
        if (consume) begin
          sent_d = sent_q + 1'b1;
          if (sent_q == LastIdx) begin
            state_d   = StDone;
            cur_vld_d = 1'b0;
            nxt_vld_d = 1'b0;
            rd_pend_d = 1'b0;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      sent_q     <= '0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      cur_q      <= '0;
      nxt_q      <= '0;
      cur_vld_q  <= 1'b0;
      nxt_vld_q  <= 1'b0;
      byte_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      sent_q     <= sent_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= rd_pend_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      cur_vld_q  <= cur_vld_d;
      nxt_vld_q  <= nxt_vld_d;
      byte_sel_q <= byte_sel_d;
    end
  end

  sample_ram #(
    .Depth (DEPTH),
    .Width (SampleWidth)
  ) u_sample_ram (
    .clk_i   (comm_clock),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.bus_address, bus.bus_data}),
    .raddr_i (rd_ptr_q[AddrW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign bus.out_valid = cur_vld_q;
  assign bus.out_data  = cur_vld_q ? sample_byte(cur_q, byte_sel_q) : 8'h00;
  assign record_done   = (state_q == StDone);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_bus_recorder.sv
// Self-checking bench for bus_recorder with DEPTH=4: table-driven dump, random
// backpressure, strobe/start corner cases and reset during dump.
module tb_bus_recorder;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic comm_reset;
  logic record_start;
  logic record_done;
  logic busy;

  bus_recorder_if bif ();

  bus_recorder #(
    .DEPTH (DEPTH)
  ) dut (
    .comm_clock   (clk),
    .comm_reset   (comm_reset),
    .record_start (record_start),
    .record_done  (record_done),
    .busy         (busy),
    .bus          (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [23:0] exp_bytes;
  } vec_t;

  int n_checks = 0;
  int n_pass = 0;

  // Monitor state
  int         cyc = 0;
  logic [7:0] rx[$];
  int         xfer_cyc[$];
  int         done_cnt = 0;
  int         hold_err = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic       rand_ready = 1'b0;

  // Reference model: samples the recorder should hold for the current capture
  logic [23:0] model[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ntick();
    @(negedge clk);
    #1;
  endtask

  // Sampling on the falling edge: valid&ready here means the byte moves at the next rise.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (comm_reset) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend && (!bif.out_valid || bif.out_data != hold_data)) hold_err++;
        if (bif.out_valid && bif.out_ready) begin
          rx.push_back(bif.out_data);
          xfer_cyc.push_back(cyc);
        end
        hold_pend = bif.out_valid && !bif.out_ready;
        hold_data = bif.out_data;
        if (record_done) done_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bif.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic clr();
    rx.delete();
    xfer_cyc.delete();
    done_cnt = 0;
    hold_err = 0;
  endtask

  task automatic pulse_start(input logic stb, input logic [15:0] a, input logic [7:0] d);
    record_start     = 1'b1;
    bif.bus_strobe   = stb;
    bif.bus_address  = a;
    bif.bus_data     = d;
    tick();
    record_start     = 1'b0;
    bif.bus_strobe   = 1'b0;
  endtask

  task automatic start_rec(input logic stb, input logic [15:0] a, input logic [7:0] d);
    model.delete();
    pulse_start(stb, a, d);
  endtask

  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    bif.bus_strobe  = 1'b1;
    bif.bus_address = a;
    bif.bus_data    = d;
    tick();
    bif.bus_strobe  = 1'b0;
    if (model.size() < DEPTH) model.push_back({a, d});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      ntick();
      n++;
    end
    check({name, " done seen"}, int'(done_cnt != 0), 1);
    ntick();
    ntick();
    check({name, " one done pulse"}, done_cnt, 1);
    check({name, " busy after done"}, int'(busy), 0);
  endtask

  task automatic compare_model(input string name);
    logic [7:0] exp[$];
    foreach (model[i]) begin
      exp.push_back(model[i][23:16]);
      exp.push_back(model[i][15:8]);
      exp.push_back(model[i][7:0]);
    end
    check({name, " byte count"}, rx.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx.size(); i++) begin
      check($sformatf("%s byte %0d", name, i), int'(rx[i]), int'(exp[i]));
    end
  endtask

  initial begin
    vec_t tbl[4];
    int   c0;
    int   n;
    logic [23:0] e;

    tbl[0] = '{16'h1234, 8'hAB, 24'h12_34_AB};
    tbl[1] = '{16'h0001, 8'h02, 24'h00_01_02};
    tbl[2] = '{16'hFFFF, 8'hFF, 24'hFF_FF_FF};
    tbl[3] = '{16'h8000, 8'h00, 24'h80_00_00};

    comm_reset      = 1'b1;
    record_start    = 1'b0;
    bif.bus_strobe  = 1'b0;
    bif.bus_address = 16'h0;
    bif.bus_data    = 8'h0;
    bif.out_ready   = 1'b1;
    repeat (3) ntick();
    check("reset busy", int'(busy), 0);
    check("reset out_valid", int'(bif.out_valid), 0);
    check("reset out_data", int'(bif.out_data), 0);
    check("reset record_done", int'(record_done), 0);
    tick();
    comm_reset = 1'b0;
    tick();

    // Directed table, ready held high: byte order, latency, back-to-back transfers
    clr();
    start_rec(1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 4; i++) strobe(tbl[i].addr, tbl[i].data);
    c0 = cyc;
    wait_done("table", 100);
    check("table byte count", rx.size(), 12);
    for (int i = 0; i < 4; i++) begin
      e = tbl[i].exp_bytes;
      for (int j = 0; j < 3; j++) begin
        if (3 * i + j < rx.size())
          check($sformatf("table byte %0d", 3 * i + j), int'(rx[3 * i + j]),
                int'(e[23 - 8 * j -: 8]));
      end
    end
    check("table latency ok", int'(xfer_cyc.size() > 0 && xfer_cyc[0] - c0 <= 3), 1);
    if (xfer_cyc.size() == 12) check("table consecutive", xfer_cyc[11] - xfer_cyc[0], 11);

    // Random data, random gaps, 50% backpressure
    for (int r = 0; r < 3; r++) begin
      clr();
      bif.out_ready = 1'b1;
      start_rec(1'b0, 16'h0, 8'h0);
      rand_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        strobe(16'($urandom), 8'($urandom));
      end
      wait_done($sformatf("rand%0d", r), 300);
      rand_ready = 1'b0;
      bif.out_ready = 1'b1;
      compare_model($sformatf("rand%0d", r));
      check($sformatf("rand%0d hold stable", r), hold_err, 0);
    end

    // Strobe coincident with start is not taken; strobes past DEPTH are dropped
    clr();
    start_rec(1'b1, 16'hDEAD, 8'h99);
    for (int i = 0; i < 6; i++) strobe(16'($urandom), 8'($urandom));
    wait_done("overflow", 100);
    compare_model("overflow");

    // record_start during CAPTURE and DUMP is ignored
    clr();
    start_rec(1'b0, 16'h0, 8'h0);
    strobe(16'hA5A5, 8'h11);
    strobe(16'h5A5A, 8'h22);
    pulse_start(1'b0, 16'h0, 8'h0);
    strobe(16'h0F0F, 8'h33);
    strobe(16'hF0F0, 8'h44);
    repeat (4) tick();
    pulse_start(1'b0, 16'h0, 8'h0);
    wait_done("restart", 100);
    compare_model("restart");
    repeat (3) ntick();
    check("restart not queued", int'(busy), 0);

    // Reset after byte 5 of the dump
    clr();
    start_rec(1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 4; i++) strobe(16'($urandom), 8'($urandom));
    n = 0;
    while (rx.size() < 5 && n < 100) begin
      ntick();
      n++;
    end
    check("abort reached byte 5", rx.size(), 5);
    @(posedge clk);
    #1;
    comm_reset = 1'b1;
    #1;
    check("abort out_valid", int'(bif.out_valid), 0);
    check("abort busy", int'(busy), 0);
    check("abort out_data", int'(bif.out_data), 0);
    tick();
    tick();
    comm_reset = 1'b0;
    repeat (20) tick();
    check("abort no done", done_cnt, 0);
    check("abort no more bytes", rx.size(), 5);

    clr();
    start_rec(1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 4; i++) strobe(16'($urandom), 8'($urandom));
    wait_done("fresh", 100);
    compare_model("fresh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_recorder.md
BUS_RECORDER -- requirements
Module: bus_recorder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of samples per capture (power of two, 2..4096).
REQ-002 SHALL have port comm_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port comm_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bus_address  input  16  target bus address to sample.
REQ-005 SHALL have port bus_data  input  8  target bus data to sample.
REQ-006 SHALL have port bus_strobe  input  1  qualifier; a sample is taken only in cycles where this is high.
REQ-007 SHALL have port record_start  input  1  single-cycle request from debug_controller to begin a capture.
REQ-008 SHALL have port record_done  output  1  single-cycle pulse when capture and dump have completed.
REQ-009 SHALL have port out_data  output  8  byte to the serial transmit FIFO.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  transmit FIFO accepts a byte this cycle.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, CAPTURE, DUMP, DONE.
REQ-014 In IDLE, SHALL go to CAPTURE and clear the write pointer on the cycle after record_start is sampled high.
REQ-015 SHALL ignore record_start in every state other than IDLE; an ignored request SHALL not be queued.
REQ-016 SHALL not capture a bus_strobe that coincides with the record_start cycle; capture begins in the first CAPTURE cycle.
REQ-017 In CAPTURE, each cycle with bus_strobe high SHALL write {bus_address, bus_data} (24 bits) at the write pointer and increment it.
REQ-018 After the write of sample DEPTH-1, SHALL go to DUMP on the next cycle; further strobes SHALL be dropped, with no wrap-around or overwrite.
REQ-019 In DUMP, SHALL emit each sample in order 0..DEPTH-1 as 3 bytes, MSB first: address[15:8], address[7:0], data.
REQ-020 A byte SHALL transfer only on a cycle where out_valid and out_ready are both high.
REQ-021 Once asserted, out_valid SHALL stay high and out_data SHALL stay stable until the transfer occurs.
REQ-022 out_valid SHALL not depend combinationally on out_ready.
REQ-023 With out_ready held high, SHALL sustain one byte per cycle after at most 2 cycles of initial latency from entering DUMP (RAM read latency hidden by prefetch).
REQ-024 After the last byte (index 3*DEPTH-1) transfers, SHALL enter DONE, pulse record_done high for exactly one cycle, and return to IDLE on the next cycle.
REQ-025 out_valid SHALL be low in IDLE, CAPTURE and DONE.
REQ-026 bus_strobe SHALL be ignored in IDLE, DUMP and DONE.

Reset
REQ-027 On comm_reset, SHALL immediately (asynchronously) set state IDLE, record_done=0, out_valid=0, out_data=8'h00, busy=0, and clear all pointers and byte counters.
REQ-028 Reset mid-capture or mid-dump SHALL abandon the operation; no record_done pulse and no further bytes SHALL follow.
REQ-029 RAM contents SHALL not be reset and SHALL not be observable before being rewritten by a new capture.

Structure
REQ-030 SHALL place the state encoding, the sample width (24), the bytes-per-sample constant (3) and CMD_RECORD (8'h30) in the shared package fidget_debug_pkg, which is also used by debug_controller.
REQ-031 SHALL instantiate exactly one sub-module, sample_ram: a simple dual-port, synchronous-read RAM, DEPTH x 24 bits, one write port and one read port.
REQ-032 SHALL keep all handshake, pointer and state logic in bus_recorder itself.

Verification
REQ-033 Bench SHALL cover this case: DEPTH=4; record_start; strobes with (addr,data) = (0x1234,0xAB), (0x0001,0x02), (0xFFFF,0xFF), (0x8000,0x00) -> bytes 12 34 AB 00 01 02 FF FF FF 80 00 00, then one record_done pulse.
REQ-034 Bench SHALL cover this case: out_ready toggled randomly at 50% during DUMP -> identical byte sequence, and out_data never changes while out_valid is high and out_ready is low.
REQ-035 Bench SHALL cover this case: bus_strobe high in the same cycle as record_start, plus 6 further strobes with DEPTH=4 -> only strobes 1..4 after start are recorded; strobes 5..6 are dropped.
REQ-036 Bench SHALL cover this case: record_start pulsed during CAPTURE and again during DUMP -> no restart, and exactly one record_done.
REQ-037 Bench SHALL cover this case: comm_reset asserted after byte 5 of the dump -> out_valid falls immediately and no record_done occurs; a following record_start produces a fresh, correct capture.
REQ-038 Bench SHALL cover this case: out_ready held high -> 12 consecutive transfer cycles after at most 2 latency cycles, and busy=0 after record_done.
